// File: rtl/data_stream_rx_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : data_stream_rx_if
//  Description : Handshake bundle for data_stream_rx: merged input stream plus
//                the demultiplexed left and right output streams.
//  Revision    : 1.0 - initial release
// ============================================================================
interface data_stream_rx_if;
  // Merged framed input stream
  logic [31:0] i_data;
  logic        i_valid;
  logic        o_ready;

  // Left channel output stream
  logic [31:0] o_l_data;
  logic        o_l_valid;
  logic        i_l_ready;

  // Right channel output stream
  logic [31:0] o_r_data;
  logic        o_r_valid;
  logic        i_r_ready;

  // Receiver view
  modport slave (
    input  i_data,
    input  i_valid,
    output o_ready,
    output o_l_data,
    output o_l_valid,
    input  i_l_ready,
    output o_r_data,
    output o_r_valid,
    input  i_r_ready
  );

  // Source / sink view
  modport master (
    output i_data,
    output i_valid,
    input  o_ready,
    input  o_l_data,
    input  o_l_valid,
    output i_l_ready,
    input  o_r_data,
    input  o_r_valid,
    output i_r_ready
  );
endinterface
`default_nettype wire

// File: rtl/data_stream_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : data_stream_rx
//  Description : Receives the merged framed word stream, checks the frame
//                structure and splits payload words into left and right
//                channel streams. Reports frame start/end, frame number and
//                format errors with a saturating error counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_stream_rx #(
  parameter int          CH_NUM    = 16,
  parameter int          BLOCK_LEN = 32,
  parameter logic [15:0] SYNC_WORD = 16'hA55A
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  data_stream_rx_if.slave  s,
  output      logic        o_frame_start,
  output      logic        o_frame_done,
  output      logic [15:0] o_frame_num,
  output      logic        o_err,
  output      logic [15:0] o_err_cnt
);

  // Word counter width; BLOCK_LEN is a power of two of at least 2
  localparam int WCNT_W = $clog2(BLOCK_LEN);

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    L_BLK = 2'd1,
    R_BLK = 2'd2
  } state_e;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  state_e              state_q,       state_d;
  logic [3:0]          ch_cnt_q,      ch_cnt_d;
  logic [WCNT_W-1:0]   word_cnt_q,    word_cnt_d;
  logic [31:0]         l_data_q,      l_data_d;
  logic                l_valid_q,     l_valid_d;
  logic [31:0]         r_data_q,      r_data_d;
  logic                r_valid_q,     r_valid_d;
  logic                frame_start_q, frame_start_d;
  logic                frame_done_q,  frame_done_d;
  logic [15:0]         frame_num_q,   frame_num_d;
  logic                err_q,         err_d;
  logic [15:0]         err_cnt_q,     err_cnt_d;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic w_ready;
  logic w_accept;
  logic w_is_sync;
  logic w_ch_ok;
  logic w_last_word;
  logic w_last_ch;
  logic w_hdr_take;

  // Input ready depends only on state and the ready of the side being filled
  always_comb begin
    w_ready = 1'b1;
    case (state_q)
      HUNT:    w_ready = 1'b1;
      L_BLK:   w_ready = ~l_valid_q | s.i_l_ready;
      R_BLK:   w_ready = ~r_valid_q | s.i_r_ready;
      default: w_ready = 1'b1;
    endcase
  end

  assign w_accept    = s.i_valid & w_ready;
  assign w_is_sync   = (s.i_data[31:16] == SYNC_WORD);
  assign w_ch_ok     = (s.i_data[31:28] == ch_cnt_q);
  assign w_last_word = (word_cnt_q == WCNT_W'(BLOCK_LEN - 1));
  assign w_last_ch   = (ch_cnt_q == 4'(CH_NUM - 1));

  // Frame tracking, demultiplexing and error detection
  always_comb begin
    state_d       = state_q;
    ch_cnt_d      = ch_cnt_q;
    word_cnt_d    = word_cnt_q;
    l_data_d      = l_data_q;
    r_data_d      = r_data_q;
    // Side registers drain on their own sink handshake regardless of state
    l_valid_d     = l_valid_q & ~s.i_l_ready;
    r_valid_d     = r_valid_q & ~s.i_r_ready;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;
    frame_num_d   = frame_num_q;
    err_d         = 1'b0;
    err_cnt_d     = err_cnt_q;
    w_hdr_take    = 1'b0;

    case (state_q)
      HUNT: begin
        // Anything that is not a header is dropped silently while hunting
        if (w_accept && w_is_sync) begin
          w_hdr_take = 1'b1;
        end
      end

      L_BLK: begin
        if (w_accept) begin
          if (w_ch_ok) begin
            l_data_d  = s.i_data;
            l_valid_d = 1'b1;
            if (w_last_word) begin
              word_cnt_d = '0;
              state_d    = R_BLK;
            end else begin
              word_cnt_d = word_cnt_q + 1'b1;
            end
          end else begin
            err_d = 1'b1;
            if (w_is_sync) begin
              w_hdr_take = 1'b1;
            end else begin
              state_d = HUNT;
            end
          end
        end
      end

      R_BLK: begin
        if (w_accept) begin
          if (w_ch_ok) begin
            r_data_d  = s.i_data;
            r_valid_d = 1'b1;
            if (w_last_word) begin
              word_cnt_d = '0;
              if (w_last_ch) begin
                frame_done_d = 1'b1;
                state_d      = HUNT;
              end else begin
                ch_cnt_d = ch_cnt_q + 1'b1;
                state_d  = L_BLK;
              end
            end else begin
              word_cnt_d = word_cnt_q + 1'b1;
            end
          end else begin
            err_d = 1'b1;
            if (w_is_sync) begin
              w_hdr_take = 1'b1;
            end else begin
              state_d = HUNT;
            end
          end
        end
      end

      default: begin
        state_d = HUNT;
      end
    endcase

    // A header restarts the frame, whether found while hunting or mid-frame
    if (w_hdr_take) begin
      frame_num_d   = s.i_data[15:0];
      frame_start_d = 1'b1;
      ch_cnt_d      = '0;
      word_cnt_d    = '0;
      state_d       = L_BLK;
    end

    // Error counter sticks at all-ones instead of wrapping
    if (err_d && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  // State and output registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= HUNT;
      ch_cnt_q      <= '0;
      word_cnt_q    <= '0;
      l_data_q      <= '0;
      l_valid_q     <= 1'b0;
      r_data_q      <= '0;
      r_valid_q     <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_num_q   <= '0;
      err_q         <= 1'b0;
      err_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      ch_cnt_q      <= ch_cnt_d;
      word_cnt_q    <= word_cnt_d;
      l_data_q      <= l_data_d;
      l_valid_q     <= l_valid_d;
      r_data_q      <= r_data_d;
      r_valid_q     <= r_valid_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
      frame_num_q   <= frame_num_d;
      err_q         <= err_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign s.o_ready     = w_ready;
  assign s.o_l_data    = l_data_q;
  assign s.o_l_valid   = l_valid_q;
  assign s.o_r_data    = r_data_q;
  assign s.o_r_valid   = r_valid_q;
  assign o_frame_start = frame_start_q;
  assign o_frame_done  = frame_done_q;
  assign o_frame_num   = frame_num_q;
  assign o_err         = err_q;
  assign o_err_cnt     = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_data_stream_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_data_stream_rx
//  Description : Directed self-checking bench for data_stream_rx.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_stream_rx;

  localparam int          CH_NUM    = 16;
  localparam int          BLOCK_LEN = 32;
  localparam logic [15:0] SYNC      = 16'hA55A;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_start, frame_done, err;
  logic [15:0] frame_num, err_cnt;

  always #5 clk = ~clk;

  data_stream_rx_if bus ();

  data_stream_rx #(
    .CH_NUM    (CH_NUM),
    .BLOCK_LEN (BLOCK_LEN),
    .SYNC_WORD (SYNC)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s             (bus),
    .o_frame_start (frame_start),
    .o_frame_done  (frame_done),
    .o_frame_num   (frame_num),
    .o_err         (err),
    .o_err_cnt     (err_cnt)
  );

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] obs_l[$], obs_r[$], exp_l[$], exp_r[$];
  int base_l = 0, base_r = 0;
  int fs_cnt = 0, fd_cnt = 0, err_pulses = 0, rdy_low = 0;
  int s_fs, s_fd, s_err, s_rdy;
  int bad_rdy, bad_data, bad_l;

  // Observe output handshakes and event pulses between clock edges
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.o_l_valid && bus.i_l_ready) obs_l.push_back(bus.o_l_data);
      if (bus.o_r_valid && bus.i_r_ready) obs_r.push_back(bus.o_r_data);
      if (frame_start) fs_cnt++;
      if (frame_done)  fd_cnt++;
      if (err)         err_pulses++;
      if (!bus.o_ready) rdy_low++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Payload word: channel nibble on top, side bit, test tag, word index
  function automatic logic [31:0] pw(input int tag, input int ch, input bit right, input int w);
    return {4'(ch), right, 3'(tag), 24'(w)};
  endfunction

  task automatic send(input logic [31:0] w);
    int n;
    n = 0;
    bus.i_data  = w;
    bus.i_valid = 1'b1;
    @(negedge clk);
    while (!bus.o_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      n_fail++;
      $display("FAIL send_timeout: observed o_ready=0 for %0d cycles expected 1", n);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $fatal(1, "send timeout");
    end
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
  endtask

  task automatic send_blk(input int tag, input int ch, input bit right,
                          input int start, input int n, input bit push);
    logic [31:0] w;
    for (int k = start; k < start + n; k++) begin
      w = pw(tag, ch, right, k);
      send(w);
      if (push) begin
        if (right) exp_r.push_back(w);
        else       exp_l.push_back(w);
      end
    end
  endtask

  task automatic send_body(input int tag, input int first_ch);
    for (int c = first_ch; c < CH_NUM; c++) begin
      send_blk(tag, c, 1'b0, 0, BLOCK_LEN, 1'b1);
      send_blk(tag, c, 1'b1, 0, BLOCK_LEN, 1'b1);
    end
  endtask

  task automatic snap();
    s_fs  = fs_cnt;
    s_fd  = fd_cnt;
    s_err = err_pulses;
    s_rdy = rdy_low;
  endtask

  // Compare everything delivered since the last check with the expected lists
  task automatic check_streams(input string tag);
    repeat (4) @(posedge clk);
    #1;
    chk({tag, "_l_count"}, 32'(obs_l.size() - base_l), 32'(exp_l.size()));
    chk({tag, "_r_count"}, 32'(obs_r.size() - base_r), 32'(exp_r.size()));
    for (int i = 0; i < exp_l.size(); i++)
      if (base_l + i < obs_l.size()) chk({tag, "_l_word"}, obs_l[base_l + i], exp_l[i]);
    for (int i = 0; i < exp_r.size(); i++)
      if (base_r + i < obs_r.size()) chk({tag, "_r_word"}, obs_r[base_r + i], exp_r[i]);
    base_l = obs_l.size();
    base_r = obs_r.size();
    exp_l.delete();
    exp_r.delete();
  endtask

  initial begin
    logic [31:0] w, g;
    bus.i_data    = '0;
    bus.i_valid   = 1'b0;
    bus.i_l_ready = 1'b1;
    bus.i_r_ready = 1'b1;

    // ---- Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_l_valid", 32'(bus.o_l_valid), 32'd0);
    chk("rst_r_valid", 32'(bus.o_r_valid), 32'd0);
    chk("rst_frame_num", 32'(frame_num), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("hunt_ready", 32'(bus.o_ready), 32'd1);

    // ---- Clean frame, header 0xA55A0007
    snap();
    send({SYNC, 16'h0007});
    send_body(0, 0);
    check_streams("clean");
    chk("clean_frame_num", 32'(frame_num), 32'h7);
    chk("clean_fs", 32'(fs_cnt - s_fs), 32'd1);
    chk("clean_fd", 32'(fd_cnt - s_fd), 32'd1);
    chk("clean_err", 32'(err_pulses - s_err), 32'd0);
    chk("clean_ready_low", 32'(rdy_low - s_rdy), 32'd0);

    // ---- Backpressure on the right side for 100 cycles mid R-block
    snap();
    send({SYNC, 16'h0001});
    send_blk(1, 0, 1'b0, 0, BLOCK_LEN, 1'b1);
    send_blk(1, 0, 1'b1, 0, 5, 1'b1);
    bus.i_r_ready = 1'b0;
    w = pw(1, 0, 1'b1, 5);
    bus.i_data  = w;
    bus.i_valid = 1'b1;
    bad_rdy = 0; bad_data = 0; bad_l = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus.o_ready) bad_rdy++;
      if (!bus.o_r_valid || bus.o_r_data !== pw(1, 0, 1'b1, 4)) bad_data++;
      if (bus.o_l_valid) bad_l++;
    end
    chk("bp_ready_low", 32'(bad_rdy), 32'd0);
    chk("bp_r_data_held", 32'(bad_data), 32'd0);
    chk("bp_l_idle", 32'(bad_l), 32'd0);
    @(posedge clk);
    #1;
    bus.i_r_ready = 1'b1;
    bus.i_valid   = 1'b0;
    send(w);
    exp_r.push_back(w);
    send_blk(1, 0, 1'b1, 6, BLOCK_LEN - 6, 1'b1);
    send_body(1, 1);
    check_streams("bp");
    chk("bp_fd", 32'(fd_cnt - s_fd), 32'd1);
    chk("bp_err", 32'(err_pulses - s_err), 32'd0);

    // ---- Channel error in ch 3 L block
    snap();
    send({SYNC, 16'h0002});
    send_body_partial: begin
      for (int c = 0; c < 3; c++) begin
        send_blk(2, c, 1'b0, 0, BLOCK_LEN, 1'b1);
        send_blk(2, c, 1'b1, 0, BLOCK_LEN, 1'b1);
      end
    end
    send_blk(2, 3, 1'b0, 0, 4, 1'b1);
    send(32'h5000_0123);
    send_blk(2, 3, 1'b0, 5, 3, 1'b0);
    check_streams("cherr");
    chk("cherr_err_pulse", 32'(err_pulses - s_err), 32'd1);
    chk("cherr_err_cnt", 32'(err_cnt), 32'd1);
    chk("cherr_fd", 32'(fd_cnt - s_fd), 32'd0);
    chk("cherr_ready", 32'(bus.o_ready), 32'd1);

    // ---- Header 0xA55A0009 at ch 2 word 10
    snap();
    send({SYNC, 16'h0003});
    for (int c = 0; c < 2; c++) begin
      send_blk(3, c, 1'b0, 0, BLOCK_LEN, 1'b1);
      send_blk(3, c, 1'b1, 0, BLOCK_LEN, 1'b1);
    end
    send_blk(3, 2, 1'b0, 0, 10, 1'b1);
    send({SYNC, 16'h0009});
    send_body(4, 0);
    check_streams("hdrin");
    chk("hdrin_frame_num", 32'(frame_num), 32'h9);
    chk("hdrin_err_pulse", 32'(err_pulses - s_err), 32'd1);
    chk("hdrin_err_cnt", 32'(err_cnt), 32'd2);
    chk("hdrin_fs", 32'(fs_cnt - s_fs), 32'd2);
    chk("hdrin_fd", 32'(fd_cnt - s_fd), 32'd1);

    // ---- Garbage before a header
    snap();
    for (int k = 0; k < 5; k++) begin
      g = $urandom();
      if (g[31:16] == SYNC) g[31] = ~g[31];
      send(g);
    end
    send({SYNC, 16'h0004});
    send_body(5, 0);
    check_streams("garb");
    chk("garb_err_pulse", 32'(err_pulses - s_err), 32'd0);
    chk("garb_err_cnt", 32'(err_cnt), 32'd2);
    chk("garb_frame_num", 32'(frame_num), 32'h4);
    chk("garb_fs", 32'(fs_cnt - s_fs), 32'd1);
    chk("garb_fd", 32'(fd_cnt - s_fd), 32'd1);

    // ---- Reset asserted mid R-block with a word pending on the right
    send({SYNC, 16'h0005});
    send_blk(6, 0, 1'b0, 0, BLOCK_LEN, 1'b0);
    send_blk(6, 0, 1'b1, 0, 5, 1'b0);
    bus.i_r_ready = 1'b0;
    chk("pre_rst_r_valid", 32'(bus.o_r_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mrst_r_valid", 32'(bus.o_r_valid), 32'd0);
    chk("mrst_r_data", bus.o_r_data, 32'd0);
    chk("mrst_l_valid", 32'(bus.o_l_valid), 32'd0);
    chk("mrst_l_data", bus.o_l_data, 32'd0);
    chk("mrst_frame_num", 32'(frame_num), 32'd0);
    chk("mrst_err_cnt", 32'(err_cnt), 32'd0);
    chk("mrst_pulses", 32'({frame_start, frame_done, err}), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.i_r_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_ready", 32'(bus.o_ready), 32'd1);
    chk("post_rst_r_valid", 32'(bus.o_r_valid), 32'd0);
    base_l = obs_l.size();
    base_r = obs_r.size();
    exp_l.delete();
    exp_r.delete();
    snap();
    send_blk(6, 0, 1'b1, 5, 3, 1'b0);
    send({SYNC, 16'h0006});
    send_body(7, 0);
    check_streams("recov");
    chk("recov_frame_num", 32'(frame_num), 32'h6);
    chk("recov_err_cnt", 32'(err_cnt), 32'd0);
    chk("recov_fs", 32'(fs_cnt - s_fs), 32'd1);
    chk("recov_fd", 32'(fd_cnt - s_fd), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/data_stream_rx.md
Name: data_stream_rx

Overview:
- Receive-side counterpart of data_stream. Consumes the merged 32-bit framed word stream and checks frame structure.
- Demultiplexes words back into separate left and right channel streams, each with valid/ready.
- Sits at the far end of the link, feeding per-side channel processing. Reports frame start/end, frame number and format errors.

Parameters:
- CH_NUM, 16, channels per side per frame (1..16).
- BLOCK_LEN, 32, words per channel block (power of two, 2..256).
- SYNC_WORD, 16'hA55A, header marker in bits [31:16] of the header word.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- i_data  in  32  merged stream word
- i_valid  in  1  i_data valid
- o_ready  out  1  block accepts i_data this cycle
- o_l_data  out  32  left word, passed through unmodified
- o_l_valid  out  1  left word valid
- i_l_ready  in  1  left sink ready
- o_r_data  out  32  right word, passed through unmodified
- o_r_valid  out  1  right word valid
- i_r_ready  in  1  right sink ready
- o_frame_start  out  1  one-cycle pulse when a header is accepted
- o_frame_done  out  1  one-cycle pulse when the last R word of a frame is accepted
- o_frame_num  out  16  frame number from the last accepted header
- o_err  out  1  one-cycle pulse on a format error
- o_err_cnt  out  16  saturating error count

Behaviour:
- Frame format: header word {SYNC_WORD, frame_num[15:0]}, then for ch = 0..CH_NUM-1: BLOCK_LEN L words, then BLOCK_LEN R words. Every payload word carries data[31:28] == ch.
- Transfer on the input side occurs when i_valid & o_ready. Output handshakes are standard: a word is held stable until valid & ready.
- Reset: all outputs 0; state HUNT; ch_cnt = 0; word_cnt = 0; o_err_cnt = 0.
- States:
  - HUNT: o_ready = 1. Non-matching words are dropped silently, with no error. A word with [31:16] == SYNC_WORD sets o_frame_num <= [15:0], pulses o_frame_start next cycle, clears ch_cnt and word_cnt, and moves to L_BLK.
  - L_BLK: o_ready = ~o_l_valid | i_l_ready. An accepted word is loaded into o_l_data with o_l_valid = 1 next cycle (1-cycle latency) and increments word_cnt. After BLOCK_LEN words: word_cnt <= 0, go to R_BLK.
  - R_BLK: mirror of L_BLK on the right side. After BLOCK_LEN words: if ch_cnt == CH_NUM-1, pulse o_frame_done and go to HUNT; else ch_cnt++ and go to L_BLK.
- Error check, applied in L_BLK and R_BLK on every accepted word:
  - If [31:28] != ch_cnt, the word is discarded (not output).
  - o_err pulses next cycle, o_err_cnt increments (saturates at 16'hFFFF), and state goes to HUNT.
  - Exception: if the mismatching word has [31:16] == SYNC_WORD, o_err still pulses, but the word is treated as a new header immediately (L_BLK, frame_start pulse), with no word lost.
- Output registers drain independently of state. A pending o_l_valid/o_r_valid is never dropped by an error or a state change.
- Full throughput: one word per clock when the target sink's ready is held high.
- Backpressure:
  - o_ready depends only on registered state and the target-side ready; there is no combinational path from i_valid.
  - The non-target side's ready is ignored.
- Simultaneous events:
  - An accept into a side register and a drain of the same register in the same cycle replaces the word, with valid kept at 1.
  - frame_done and a following header can occur on consecutive cycles.
- Reset mid-frame: immediate return to reset values, with no partial output.

Test Plan:
- Clean frame, CH_NUM=16, BLOCK_LEN=32, header 32'hA55A0007, both readies = 1:
  - 512 L words out in order, followed by 512 R words (as 16 alternating blocks).
  - o_frame_num = 16'h0007; one frame_start and one frame_done pulse; o_ready stays high; o_err never pulses.
- Backpressure: i_r_ready low for 100 cycles mid R-block:
  - o_ready low while o_r_valid is pending; o_r_data held stable; no words lost or duplicated; L-side idle.
- Channel error: word in ch 3 L block with [31:28] = 4'h5:
  - o_err pulses, o_err_cnt = 1, word not output, state returns to HUNT; following words dropped until the next header.
- Header inside payload: 32'hA55A0009 appears at ch 2 word 10:
  - o_err pulses, o_frame_start pulses, o_frame_num = 9; the next word is accepted as ch 0 L.
- Garbage before header: 5 random non-sync words then a valid frame:
  - no o_err, no output for the garbage, normal frame delivered.
- rst_n asserted mid R-block:
  - all outputs 0 immediately; after release the block sits in HUNT and recovers on the next header.
